// File: rtl/obi_arb_pkg.sv
// rtl/obi_arb_pkg.sv - shared types and helpers for the OBI round-robin arbiter
// Purpose: request-info struct, initiator index type, FSM state and the
//          round-robin pointer advance used by the arbiter and its routing FIFO.
package obi_arb_pkg;

    // Index type is sized for the largest supported initiator count (8),
    // so the routing FIFO can be reused unchanged for any NUM_REQ in 2..8.
    localparam int unsigned ARB_MAX_REQ = 8;
    localparam int unsigned ARB_IDXW    = $clog2(ARB_MAX_REQ);

    localparam int unsigned ARB_ADDRW = 32;
    localparam int unsigned ARB_DATAW = 32;
    localparam int unsigned ARB_STRBW = ARB_DATAW / 8;

    typedef logic [ARB_IDXW-1:0] idx_t;

    typedef struct packed {
        logic [ARB_ADDRW-1:0] addr;
        logic                 we;
        logic [ARB_DATAW-1:0] wdata;
        logic [ARB_STRBW-1:0] be;
    } obi_req_info_t;

    // ST_HOLD keeps the address phase of the selected initiator stable
    // until the downstream port grants it.
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    function automatic idx_t rr_next(input idx_t cur, input int unsigned num_req);
        if ((32'(cur) + 32'd1) >= num_req) begin
            return '0;
        end
        return cur + idx_t'(1);
    endfunction

endpackage

// File: rtl/obi_arb_route_fifo.sv
// rtl/obi_arb_route_fifo.sv - in-order FIFO of initiator indices for response routing
// Purpose: remembers which initiator owns each outstanding transaction.
// Ports:   clk_i, rst_i (sync, active-high), push_i/push_idx_i write side,
//          pop_i/head_o read side, count_o occupancy, full_o, empty_o.
module obi_arb_route_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  idx_t                       push_idx_i,
    input  logic                       pop_i,
    output idx_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    idx_t            r_mem [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [CNTW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNTW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push_i & ~w_full;
    assign w_do_pop  = pop_i & ~w_empty;

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign full_o  = w_full;
    assign empty_o = w_empty;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_idx_i;
        end
    end

    // Explicit wrap keeps non-power-of-two depths correct.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTRW'(DEPTH - 1)) ? '0 : r_wr_ptr + PTRW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTRW'(DEPTH - 1)) ? '0 : r_rd_ptr + PTRW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - round-robin arbiter sharing one OBI target among NUM_REQ initiators
// Purpose: selects one initiator per cycle, holds its address phase until
//          granted, and steers each response back through an in-order FIFO.
// Ports:   clk_obi_i/rst_i; s_* upstream initiator ports (per-initiator vectors,
//          s_rdata_o broadcast); m_* downstream target port; outstanding_o
//          FIFO occupancy; err_o sticky response-with-nothing-outstanding flag.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned OBI_ADDRW       = ARB_ADDRW,
    parameter int unsigned OBI_DATAW       = ARB_DATAW,
    parameter int unsigned OBI_STRBW       = OBI_DATAW / 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_obi_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   s_req_i,
    input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]    s_addr_i,
    input  logic [NUM_REQ-1:0]                   s_we_i,
    input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]    s_wdata_i,
    input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]    s_be_i,
    output logic [NUM_REQ-1:0]                   s_gnt_o,
    output logic [NUM_REQ-1:0]                   s_rvalid_o,
    output logic [OBI_DATAW-1:0]                 s_rdata_o,
    output logic                                 m_req_o,
    output logic [OBI_ADDRW-1:0]                 m_addr_o,
    output logic                                 m_we_o,
    output logic [OBI_DATAW-1:0]                 m_wdata_o,
    output logic [OBI_STRBW-1:0]                 m_be_o,
    input  logic                                 m_gnt_i,
    input  logic                                 m_rvalid_i,
    input  logic [OBI_DATAW-1:0]                 m_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t    r_state;
    idx_t          r_rr_ptr;
    idx_t          r_lock_idx;
    logic          r_err;

    idx_t          w_sel;
    logic          w_found;
    obi_req_info_t w_info;
    logic          w_mreq;
    logic          w_hs;
    logic          w_pop;
    idx_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic [CNTW-1:0] w_count;

    // Two passes: indices at/above the pointer first, then the wrap-around
    // part below it. With nothing requesting, sel rests on the pointer.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_found = 1'b0;
        if (r_state == ST_HOLD) begin
            w_sel = r_lock_idx;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && s_req_i[i] && (idx_t'(i) >= r_rr_ptr)) begin
                    w_found = 1'b1;
                    w_sel   = idx_t'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && s_req_i[i] && (idx_t'(i) < r_rr_ptr)) begin
                    w_found = 1'b1;
                    w_sel   = idx_t'(i);
                end
            end
        end
    end

    always_comb begin
        w_info = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_t'(i) == w_sel) begin
                w_info.addr  = s_addr_i[i];
                w_info.we    = s_we_i[i];
                w_info.wdata = s_wdata_i[i];
                w_info.be    = s_be_i[i];
            end
        end
    end

    // Full is taken from the registered count only: a pop in the same cycle
    // does not reopen issue until the next cycle.
    assign w_mreq = ~rst_i & ((|s_req_i) | (r_state == ST_HOLD)) & ~w_full;
    assign w_hs   = w_mreq & m_gnt_i;
    assign w_pop  = ~rst_i & m_rvalid_i & ~w_empty;

    always_comb begin
        s_gnt_o    = '0;
        s_rvalid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_gnt_o[i]    = w_hs  && (idx_t'(i) == w_sel);
            s_rvalid_o[i] = w_pop && (idx_t'(i) == w_head);
        end
    end

    assign m_req_o       = w_mreq;
    assign m_addr_o      = w_info.addr;
    assign m_we_o        = w_info.we;
    assign m_wdata_o     = w_info.wdata;
    assign m_be_o        = w_info.be;
    assign s_rdata_o     = m_rdata_i;
    assign outstanding_o = w_count;
    assign err_o         = r_err;

    always_ff @(posedge clk_obi_i) begin
        if (rst_i) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_hs) begin
                        r_rr_ptr <= rr_next(w_sel, NUM_REQ);
                    end else if (w_mreq) begin
                        r_state    <= ST_HOLD;
                        r_lock_idx <= w_sel;
                    end
                end
                ST_HOLD: begin
                    if (w_hs) begin
                        r_rr_ptr <= rr_next(w_sel, NUM_REQ);
                        r_state  <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
            if (m_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    obi_arb_route_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i      (clk_obi_i),
        .rst_i      (rst_i),
        .push_i     (w_hs),
        .push_idx_i (w_sel),
        .pop_i      (w_pop),
        .head_o     (w_head),
        .count_o    (w_count),
        .full_o     (w_full),
        .empty_o    (w_empty)
    );

endmodule
